// File: rtl/rand_arbiter_pkg.sv
// rand_arbiter_pkg: shared types and defaults for the random-number arbiter.
//   state_t     - arbiter FSM states
//   *_DEF       - default NREQ / WIDTH / MAX_TRY values
//   LFSR_SEED   - reset value of the shared 8-bit LFSR
package rand_arbiter_pkg;

    localparam int unsigned NREQ_DEF    = 4;
    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned MAX_TRY_DEF = 15;
    localparam logic [7:0]  LFSR_SEED   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/rand_arbiter_if.sv
// rand_arbiter_if: request/LFSR/result bundle between consumers and the arbiter.
//   en, req, limit      - requester controls (per-requester limit slices)
//   lfsr_value          - current LFSR state into the arbiter
//   lfsr_hold           - LFSR freeze control from the arbiter
//   grant, rand_out,
//   rand_valid, rand_fail - transaction owner and result handshake
// Modports: master = requester/LFSR side, slave = arbiter side.
interface rand_arbiter_if
    import rand_arbiter_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned WIDTH = WIDTH_DEF
);
    logic                    en;
    logic [NREQ-1:0]         req;
    logic [NREQ*WIDTH-1:0]   limit;
    logic [WIDTH-1:0]        lfsr_value;
    logic                    lfsr_hold;
    logic [NREQ-1:0]         grant;
    logic [WIDTH-1:0]        rand_out;
    logic                    rand_valid;
    logic                    rand_fail;

    modport master (
        output en, req, limit, lfsr_value,
        input  lfsr_hold, grant, rand_out, rand_valid, rand_fail
    );

    modport slave (
        input  en, req, limit, lfsr_value,
        output lfsr_hold, grant, rand_out, rand_valid, rand_fail
    );
endinterface

// File: rtl/rand_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder.
//   req    - request vector
//   ptr    - index where the search starts
//   winner - first requesting index at or after ptr (cyclic)
//   any    - at least one request present
module rr_picker
    import rand_arbiter_pkg::*;
#(
    parameter  int unsigned NREQ = NREQ_DEF,
    localparam int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any
);

    always_comb begin
        logic [IW-1:0] idx;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IW'((32'(ptr) + k) % NREQ);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/rand_arbiter.sv
// rand_arbiter: round-robin owner of the shared LFSR. Each grant shifts the
// LFSR WIDTH times, then applies rejection sampling against the winner's
// latched exclusive bound (0 = unbounded), retrying up to MAX_TRY draws.
//   clk, rst - clock, asynchronous active-low reset
//   bus      - rand_arbiter_if.slave (requests, LFSR link, result handshake)
// Optional: RAND_ARBITER_STATS_EN adds saturating counters
//   stat_draws   - completed DRAW phases
//   stat_rejects - CHECK rejections
module rand_arbiter
    import rand_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned MAX_TRY = MAX_TRY_DEF
) (
    input  logic          clk,
    input  logic          rst,
    rand_arbiter_if.slave bus
`ifdef RAND_ARBITER_STATS_EN
    ,
    output logic [15:0]   stat_draws,
    output logic [15:0]   stat_rejects
`endif
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned SW = $clog2(WIDTH + 1);

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr, winner, pick;
    logic             any;
    logic [WIDTH-1:0] lim_q, lim_sel, rand_out_q;
    logic [SW-1:0]    shift_cnt;
    logic [7:0]       try_cnt;
    logic             fail_q;
    logic             start, accept, last_shift, last_try;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (pick),
        .any    (any)
    );

    assign start      = bus.en && any;
    assign lim_sel    = bus.limit[pick*WIDTH +: WIDTH];
    assign accept     = (lim_q == '0) || (bus.lfsr_value < lim_q);
    assign last_shift = (shift_cnt == SW'(WIDTH - 1));
    assign last_try   = ((9'(try_cnt) + 9'd1) == 9'(MAX_TRY));
    assign bus.rand_out = rand_out_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = DRAW;
            DRAW:    if (last_shift) state_nxt = CHECK;
            CHECK:   state_nxt = (accept || last_try) ? DONE : DRAW;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // grant is derived from state so it drops the moment reset hits.
    always_comb begin
        bus.lfsr_hold  = 1'b1;
        bus.grant      = '0;
        bus.rand_valid = 1'b0;
        bus.rand_fail  = 1'b0;
        unique case (state)
            IDLE: ;
            DRAW: begin
                bus.lfsr_hold     = 1'b0;
                bus.grant[winner] = 1'b1;
            end
            CHECK: bus.grant[winner] = 1'b1;
            DONE: begin
                bus.grant[winner] = 1'b1;
                bus.rand_valid    = 1'b1;
                bus.rand_fail     = fail_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr        <= '0;
            winner     <= '0;
            lim_q      <= '0;
            shift_cnt  <= '0;
            try_cnt    <= '0;
            fail_q     <= 1'b0;
            rand_out_q <= '0;
        end else begin
            unique case (state)
                IDLE: if (start) begin
                    winner    <= pick;
                    lim_q     <= lim_sel;
                    shift_cnt <= '0;
                    try_cnt   <= '0;
                    fail_q    <= 1'b0;
                end
                DRAW: shift_cnt <= last_shift ? '0 : shift_cnt + 1'b1;
                CHECK: begin
                    if (accept) begin
                        rand_out_q <= bus.lfsr_value;
                    end else if (last_try) begin
                        rand_out_q <= '0;
                        fail_q     <= 1'b1;
                    end else begin
                        try_cnt <= try_cnt + 8'd1;
                    end
                end
                DONE: ptr <= (winner == IW'(NREQ - 1)) ? '0 : winner + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef RAND_ARBITER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_draws   <= '0;
            stat_rejects <= '0;
        end else begin
            if (state == DRAW && last_shift && stat_draws != '1)
                stat_draws <= stat_draws + 16'd1;
            if (state == CHECK && !accept && stat_rejects != '1)
                stat_rejects <= stat_rejects + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rand_arbiter.sv
// tb_rand_arbiter: self-checking bench for rand_arbiter. Provides the
// external 8-bit LFSR (taps 7,5,4,3, seed 0xFF) and predicts each
// transaction from a draw-level model of grant order and rejection sampling.
module tb_rand_arbiter;
    import rand_arbiter_pkg::*;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 8;
    localparam int MAX_TRY = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rand_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef RAND_ARBITER_STATS_EN
    logic [15:0] stat_draws, stat_rejects;
`endif

    rand_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_TRY(MAX_TRY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RAND_ARBITER_STATS_EN
        ,
        .stat_draws   (stat_draws),
        .stat_rejects (stat_rejects)
`endif
    );

    // External LFSR driven by the arbiter's hold pin.
    logic [7:0] lfsr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                lfsr <= LFSR_SEED;
        else if (!bus.lfsr_hold) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign bus.lfsr_value = lfsr;

    logic [WIDTH-1:0] lim_arr [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_lim
        assign bus.limit[i*WIDTH +: WIDTH] = lim_arr[i];
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] m_lfsr;
    int m_ptr, m_draws, m_rejects;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] lfsr_next8(input logic [7:0] s);
        logic [7:0] v;
        v = s;
        for (int i = 0; i < 8; i++) v = {v[6:0], ^(v & 8'hB8)};
        return v;
    endfunction

    function automatic int pick_rr(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++)
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // One draw = one fresh 8-shift value; stop at first acceptance or MAX_TRY.
    task automatic predict(input logic [7:0] lim, output logic [7:0] val,
                           output int draws, output logic fail);
        val = '0; fail = 1'b1; draws = 0;
        for (int t = 0; t < MAX_TRY; t++) begin
            m_lfsr = lfsr_next8(m_lfsr);
            draws++;
            if (lim == 0 || m_lfsr < lim) begin
                val = m_lfsr; fail = 1'b0;
                break;
            end
        end
        m_draws   += draws;
        m_rejects += fail ? draws : draws - 1;
    endtask

    // perturb: 0 none, 1 change winner limit, 2 drop winner req, 3 drop en
    task automatic serve(input string tag, input int grant_wait, input int perturb, input bit drop);
        logic [NREQ-1:0] r_s, g_exp;
        logic [7:0] lim, ev;
        logic ef, stable;
        int w, n, draws;
        r_s = bus.req;
        n = 0;
        do begin tick(); n++; end while (bus.grant === '0 && n < 8);
        check({tag, " grant_wait"}, n, grant_wait);
        w = pick_rr(r_s, m_ptr);
        if (w < 0) w = 0;
        g_exp = '0; g_exp[w] = 1'b1;
        check({tag, " grant"}, bus.grant, g_exp);
        check({tag, " hold_draw"}, bus.lfsr_hold, 1'b0);
        lim = lim_arr[w];
        predict(lim, ev, draws, ef);
        case (perturb)
            1: lim_arr[w] = WIDTH'($urandom);
            2: bus.req[w] = 1'b0;
            3: bus.en = 1'b0;
            default: ;
        endcase
        n = 0; stable = 1'b1;
        do begin
            tick(); n++;
            if (bus.grant !== g_exp) stable = 1'b0;
        end while (bus.rand_valid !== 1'b1 && n < 200);
        check({tag, " latency"}, n, draws * (WIDTH + 1));
        check({tag, " rand_out"}, bus.rand_out, ev);
        check({tag, " rand_fail"}, bus.rand_fail, ef);
        check({tag, " grant_stable"}, stable, 1'b1);
        m_ptr = (w + 1) % NREQ;
        if (drop) bus.req[w] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic ok;
        int gw;
        bus.en = 1'b1;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) lim_arr[i] = '0;
        m_lfsr = LFSR_SEED; m_ptr = 0; m_draws = 0; m_rejects = 0;

        tick(); tick();
        check("rst grant", bus.grant, 4'b0000);
        check("rst hold", bus.lfsr_hold, 1'b1);
        check("rst valid", bus.rand_valid, 1'b0);
        check("rst fail", bus.rand_fail, 1'b0);
        check("rst rand_out", bus.rand_out, 8'h00);
        rst = 1'b1;
        tick();

        // First draw from seed: 8 shifts of 0xFF
        bus.req = 4'b0001;
        serve("basic", 1, 0, 1'b1);
        check("basic value", bus.rand_out, 8'h0B);

        // Rejection path; limit changed after grant must not matter
        tick();
        lim_arr[0] = 8'h0B;
        bus.req = 4'b0001;
        serve("reject", 1, 1, 1'b1);

        // limit 1 can never accept: exhausts all tries
        tick();
        lim_arr[0] = 8'h01;
        bus.req = 4'b0001;
        serve("limit1", 1, 0, 1'b1);
        check("limit1 fail", bus.rand_fail, 1'b1);

        // en low blocks grants; en dropped mid-transaction lets it finish
        tick();
        lim_arr[0] = '0; lim_arr[1] = '0;
        bus.en = 1'b0;
        bus.req = 4'b0011;
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (bus.grant !== 4'b0000 || bus.lfsr_hold !== 1'b1) ok = 1'b0;
        end
        check("en_block", ok, 1'b1);
        bus.en = 1'b1;
        serve("en_rise", 1, 3, 1'b1);
        ok = 1'b1;
        repeat (4) begin
            tick();
            if (bus.grant !== 4'b0000 || bus.rand_valid !== 1'b0) ok = 1'b0;
        end
        check("en_low_after", ok, 1'b1);
        bus.en = 1'b1;
        serve("en_resume", 1, 0, 1'b1);

        // All requesters held: strict rotation, 11 cycles between grants
        tick();
        for (int i = 0; i < NREQ; i++) lim_arr[i] = '0;
        bus.req = 4'b1111;
        serve("rr", 1, 0, 1'b0);
        for (int k = 0; k < 4; k++) serve("rr_next", 2, 0, 1'b0);
        bus.req = '0;

        // Randomized transactions
        for (int it = 0; it < 40; it++) begin
            if (bus.req == '0) begin
                tick();
                repeat ($urandom_range(0, 2)) tick();
                for (int i = 0; i < NREQ; i++) begin
                    case ($urandom_range(0, 3))
                        0:       lim_arr[i] = '0;
                        1:       lim_arr[i] = 8'h01;
                        default: lim_arr[i] = WIDTH'($urandom_range(2, 255));
                    endcase
                end
                bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
                gw = 1;
            end else begin
                gw = 2;
            end
            serve("rnd", gw, $urandom_range(0, 2), 1'b1);
        end
        bus.req = '0;
        tick(); tick();

`ifdef RAND_ARBITER_STATS_EN
        check("stat_draws", stat_draws, m_draws);
        check("stat_rejects", stat_rejects, m_rejects);
`endif

        // Reset in the middle of DRAW
        lim_arr[0] = '0;
        bus.req = 4'b0001;
        tick();
        check("pre_rst grant", bus.grant, 4'b0001);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("mid_rst grant", bus.grant, 4'b0000);
        check("mid_rst hold", bus.lfsr_hold, 1'b1);
        bus.req = '0;
        tick();
        rst = 1'b1;
        m_lfsr = LFSR_SEED; m_ptr = 0; m_draws = 0; m_rejects = 0;
        ok = 1'b1;
        repeat (12) begin
            tick();
            if (bus.rand_valid !== 1'b0) ok = 1'b0;
        end
        check("rst_no_strobe", ok, 1'b1);
        bus.req = 4'b0001;
        serve("after_rst", 1, 0, 1'b1);
        check("after_rst value", bus.rand_out, 8'h0B);
        tick();

`ifdef RAND_ARBITER_STATS_EN
        check("stat_draws_rst", stat_draws, m_draws);
        check("stat_rejects_rst", stat_rejects, m_rejects);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rand_arbiter.md
# rand_arbiter

Round-robin arbiter that shares the single 8-bit LFSR pseudo-random generator among several consumers, such as entrance gates, slot allocators and display effects. It owns the generator's hold control and advances it a full WIDTH shifts per draw, so every grant gets a fresh, decorrelated value. Each requester may supply an exclusive upper bound; the block applies rejection sampling with a bounded retry count and returns the result with a valid/fail handshake.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, random value width; equals the LFSR width
- MAX_TRY, 15, draws attempted before reporting failure (1..255)
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- en  in  1  arbitration enable; low blocks new grants only
- req  in  NREQ  per-requester level request
- limit  in  NREQ*WIDTH  per-requester exclusive bound, slice i = limit[i*WIDTH +: WIDTH]; 0 = unbounded
- lfsr_value  in  WIDTH  current LFSR state
- lfsr_hold  out  1  high freezes LFSR; low shifts it once per clk (drives LFSR power pin)
- grant  out  NREQ  one-hot owner of the current transaction
- rand_out  out  WIDTH  accepted value
- rand_valid  out  1  one-cycle completion strobe
- rand_fail  out  1  one-cycle strobe, same cycle as rand_valid, when retries are exhausted

## Operation
- FSM states: IDLE, DRAW, CHECK, DONE.
- **IDLE:** lfsr_hold=1.
  - If en and |req: pick the winner round-robin, starting the search at pointer ptr.
  - Latch the winner index and its limit; grant goes one-hot; try counter=0; shift counter=0; go to DRAW.
- **DRAW:** lfsr_hold=0. Shift counter increments each cycle; after WIDTH cycles, go to CHECK.
- **CHECK:** lfsr_hold=1. Accept if latched limit==0 or lfsr_value < latched limit.
  - Accept: rand_out<=lfsr_value; go to DONE.
  - Reject and try+1 < MAX_TRY: try++; go to DRAW.
  - Reject and try+1 == MAX_TRY: rand_out<=0, fail flag set; go to DONE.
- **DONE:** rand_valid=1, rand_fail=fail flag; ptr<=(winner+1) mod NREQ; grant cleared on exit; go to IDLE.
- The LFSR never yields 0, so limit=1 always exhausts retries and fails.
- Requester rules:
  - A requester holds req until it sees rand_valid with its grant bit.
  - A req still high in the IDLE cycle after DONE is a new request.
- Boundary conditions:
  - Dropping req mid-transaction does not abort it; the result is still strobed.
  - en low mid-transaction: the current transaction completes; no new grant follows.
  - The latched limit is immune to limit changes after the grant.
- Reset: state=IDLE, ptr=0, grant=0, rand_out=0, rand_valid=0, rand_fail=0, lfsr_hold=1.
- Reset mid-transaction returns to IDLE immediately with no strobe.

## Timing
- Req sampled at edge E0 in IDLE → grant and DRAW visible after E0.
- CHECK follows edge E0+WIDTH; DONE, with rand_valid, follows edge E0+WIDTH+1.
- Minimum latency is WIDTH+2 cycles from req sampling to strobe; each rejection adds WIDTH+1 cycles.
- Back-to-back transactions: one IDLE cycle between DONE and the next grant.
- grant is stable from the first DRAW cycle through DONE inclusive.

## Configuration
- RAND_ARBITER_STATS_EN defined: adds outputs stat_draws[15:0] (completed DRAW phases) and stat_rejects[15:0] (CHECK rejections). Both are saturating, cleared by reset.
- Not defined: both ports and their counters are absent; functional behaviour is identical.

## Structure
- rand_arbiter_pkg holds:
  - the state enum
  - default NREQ/WIDTH/MAX_TRY constants
  - LFSR_SEED = 8'hFF
- Sub-module rr_picker: combinational round-robin priority encoder. Inputs req and ptr; outputs winner index and any.

## Test plan
- Reset, then req=0001, limit0=0 → grant=0001, rand_valid after 10 cycles, rand_out=0x0B (8 shifts from seed 0xFF).
- req=0001, limit0=0x0B, MAX_TRY=2 → draws 0x0B then 0xC6, both rejected; rand_valid=rand_fail=1, rand_out=0; stats rejects=2, draws=2.
- req=1111 held continuously, limits 0 → grants in order 0001,0010,0100,1000,0001, each 11 cycles apart.
- req=0001, limit0=1, MAX_TRY=3 → fail strobe after 3 draws (3*9+1 cycles).
- en=0 with req=0011 → no grant and lfsr_hold stays 1; en rises → grant=0001 next edge.
- Reset asserted mid-DRAW → grant=0, lfsr_hold=1 immediately; no rand_valid; next transaction again yields 0x0B.
